// File: rtl/bram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : bram_port_arbiter
// Description : Round-robin arbiter (with burst lock) sharing one BRAM port
//               between two requesters; routes read data back by tag.
// Revision    : 1.0 - initial release
// ============================================================================
module bram_port_arbiter #(
  parameter int WIDTH      = 32,
  parameter int ADDRWIDTH  = 10,
  parameter int RD_LATENCY = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,

  input  logic                 r0_req,
  input  logic                 r0_we,
  input  logic                 r0_lock,
  input  logic [ADDRWIDTH-1:0] r0_addr,
  input  logic [WIDTH-1:0]     r0_di,
  output logic                 r0_gnt,
  output logic                 r0_rvalid,
  output logic [WIDTH-1:0]     r0_do,

  input  logic                 r1_req,
  input  logic                 r1_we,
  input  logic                 r1_lock,
  input  logic [ADDRWIDTH-1:0] r1_addr,
  input  logic [WIDTH-1:0]     r1_di,
  output logic                 r1_gnt,
  output logic                 r1_rvalid,
  output logic [WIDTH-1:0]     r1_do,

  output logic                 ram_en,
  output logic                 ram_we,
  output logic [ADDRWIDTH-1:0] ram_addr,
  output logic [WIDTH-1:0]     ram_di,
  input  logic [WIDTH-1:0]     ram_do,

  output logic                 busy
);

  // 0 = requester 0 has priority on contention, 1 = requester 1
  logic                 r_ptr;

  logic                 w_gnt0;
  logic                 w_gnt1;
  logic                 w_accept;
  logic                 w_acceptWe;
  logic                 w_acceptRd;
  logic [ADDRWIDTH-1:0] w_acceptAddr;
  logic [WIDTH-1:0]     w_acceptDi;

  logic                 r_ramEn;
  logic                 r_ramWe;
  logic [ADDRWIDTH-1:0] r_ramAddr;
  logic [WIDTH-1:0]     r_ramDi;

  // Stage 0 lines up with ram_en; the last stage lines up with valid ram_do.
  logic [RD_LATENCY:0]  r_pipeValid;
  logic [RD_LATENCY:0]  r_pipeTag;
  logic                 w_headValid;
  logic                 w_headTag;

  logic                 r_r0Rvalid;
  logic                 r_r1Rvalid;
  logic [WIDTH-1:0]     r_r0Do;
  logic [WIDTH-1:0]     r_r1Do;

  // Grants are gated by reset so every output reads 0 while rst_n is low.
  assign w_gnt0 = rst_n & r0_req & (~r1_req | ~r_ptr);
  assign w_gnt1 = rst_n & r1_req & (~r0_req |  r_ptr);

  always_comb begin
    w_accept     = w_gnt0 | w_gnt1;
    w_acceptWe   = 1'b0;
    w_acceptAddr = r0_addr;
    w_acceptDi   = r0_di;
    if (w_gnt1) begin
      w_acceptWe   = r1_we;
      w_acceptAddr = r1_addr;
      w_acceptDi   = r1_di;
    end else if (w_gnt0) begin
      w_acceptWe   = r0_we;
    end
    w_acceptRd = w_accept & ~w_acceptWe;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= 1'b0;
    end else if (w_gnt0) begin
      r_ptr <= ~r0_lock;
    end else if (w_gnt1) begin
      r_ptr <= r1_lock;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ramEn   <= 1'b0;
      r_ramWe   <= 1'b0;
      r_ramAddr <= '0;
      r_ramDi   <= '0;
    end else begin
      r_ramEn <= w_accept;
      r_ramWe <= w_accept & w_acceptWe;
      if (w_accept) begin
        r_ramAddr <= w_acceptAddr;
        r_ramDi   <= w_acceptDi;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pipeValid <= '0;
      r_pipeTag   <= '0;
    end else begin
      r_pipeValid <= {r_pipeValid[RD_LATENCY-1:0], w_acceptRd};
      r_pipeTag   <= {r_pipeTag[RD_LATENCY-1:0], w_gnt1};
    end
  end

  assign w_headValid = r_pipeValid[RD_LATENCY];
  assign w_headTag   = r_pipeTag[RD_LATENCY];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_r0Rvalid <= 1'b0;
      r_r1Rvalid <= 1'b0;
      r_r0Do     <= '0;
      r_r1Do     <= '0;
    end else begin
      r_r0Rvalid <= w_headValid & ~w_headTag;
      r_r1Rvalid <= w_headValid &  w_headTag;
      if (w_headValid & ~w_headTag) begin
        r_r0Do <= ram_do;
      end
      if (w_headValid & w_headTag) begin
        r_r1Do <= ram_do;
      end
    end
  end

  assign r0_gnt    = w_gnt0;
  assign r1_gnt    = w_gnt1;
  assign r0_rvalid = r_r0Rvalid;
  assign r1_rvalid = r_r1Rvalid;
  assign r0_do     = r_r0Do;
  assign r1_do     = r_r1Do;
  assign ram_en    = r_ramEn;
  assign ram_we    = r_ramWe;
  assign ram_addr  = r_ramAddr;
  assign ram_di    = r_ramDi;
  assign busy      = (|r_pipeValid) | r_r0Rvalid | r_r1Rvalid;

endmodule
`default_nettype wire

// File: tb/tb_bram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_bram_port_arbiter
// Description : Scoreboard bench for bram_port_arbiter, RD_LATENCY 4 and 1.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bram_port_arbiter;

  localparam int WIDTH = 32;
  localparam int AW    = 10;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic             reqI  [2];
  logic             weI   [2];
  logic             lockI [2];
  logic [AW-1:0]    addrI [2];
  logic [WIDTH-1:0] diI   [2];

  logic             gntO [2][2];
  logic             rvO  [2][2];
  logic [WIDTH-1:0] doO  [2][2];
  logic             ramEn   [2];
  logic             ramWe   [2];
  logic [AW-1:0]    ramAddr [2];
  logic [WIDTH-1:0] ramDi   [2];
  logic [WIDTH-1:0] ramDo   [2];
  logic             busyO   [2];

  genvar g;
  generate
    for (g = 0; g < 2; g++) begin : g_dut
      localparam int LAT = (g == 0) ? 4 : 1;

      bram_port_arbiter #(.WIDTH(WIDTH), .ADDRWIDTH(AW), .RD_LATENCY(LAT)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .r0_req(reqI[0]), .r0_we(weI[0]), .r0_lock(lockI[0]), .r0_addr(addrI[0]), .r0_di(diI[0]),
        .r0_gnt(gntO[g][0]), .r0_rvalid(rvO[g][0]), .r0_do(doO[g][0]),
        .r1_req(reqI[1]), .r1_we(weI[1]), .r1_lock(lockI[1]), .r1_addr(addrI[1]), .r1_di(diI[1]),
        .r1_gnt(gntO[g][1]), .r1_rvalid(rvO[g][1]), .r1_do(doO[g][1]),
        .ram_en(ramEn[g]), .ram_we(ramWe[g]), .ram_addr(ramAddr[g]), .ram_di(ramDi[g]),
        .ram_do(ramDo[g]), .busy(busyO[g])
      );

      // BRAM port: read registered on enable, then LAT-1 output registers
      logic [WIDTH-1:0] mem  [1024];
      logic [WIDTH-1:0] pipe [LAT];
      always @(posedge clk) begin
        if (ramEn[g] && ramWe[g]) mem[ramAddr[g]] <= ramDi[g];
        if (ramEn[g] && !ramWe[g]) pipe[0] <= mem[ramAddr[g]];
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
      end
      assign ramDo[g] = pipe[LAT-1];
    end
  endgenerate

  typedef struct {
    logic             we;
    logic             lock;
    logic [AW-1:0]    addr;
    logic [WIDTH-1:0] di;
  } tx_t;

  typedef struct {
    logic [WIDTH-1:0] data;
    int               due;
  } sb_t;

  tx_t              txq [2][$];
  sb_t              sb  [2][2][$];
  logic [WIDTH-1:0] expMem [1024];
  logic [WIDTH-1:0] lastDo [2][2];
  logic             ptr;
  logic             expEn;
  logic             expWe;
  logic [AW-1:0]    expAddr;
  logic [WIDTH-1:0] expDi;
  int               cyc;
  int               passCnt;
  int               failCnt;
  int               total;
  bit               recording;
  int               hist [$];

  function automatic int latOf(int d);
    return (d == 0) ? 4 : 1;
  endfunction

  task automatic check(string tag, int d, logic [WIDTH-1:0] obs, logic [WIDTH-1:0] exp);
    total++;
    assert (obs === exp) passCnt++;
    else begin
      failCnt++;
      $error("FAIL %s (lat %0d): got %0h, expected %0h", tag, latOf(d), obs, exp);
    end
  endtask

  task automatic pushTx(int k, logic we, logic lock, logic [AW-1:0] addr, logic [WIDTH-1:0] di);
    txq[k].push_back(tx_t'{we, lock, addr, di});
  endtask

  // One clock cycle: drive queue heads, check at negedge, then update the model.
  task automatic cycle();
    logic eg [2];
    logic expBusy;
    sb_t  e;
    for (int k = 0; k < 2; k++) begin
      if (txq[k].size() > 0) begin
        reqI[k]  = 1'b1;
        weI[k]   = txq[k][0].we;
        lockI[k] = txq[k][0].lock;
        addrI[k] = txq[k][0].addr;
        diI[k]   = txq[k][0].di;
      end else begin
        reqI[k]  = 1'b0;
        weI[k]   = 1'b0;
        lockI[k] = 1'b0;
      end
    end
    @(negedge clk);
    eg[0] = reqI[0] & (~reqI[1] | ~ptr);
    eg[1] = reqI[1] & (~reqI[0] |  ptr);
    if (recording) begin
      if (gntO[0][0]) hist.push_back(0);
      if (gntO[0][1]) hist.push_back(1);
    end
    for (int d = 0; d < 2; d++) begin
      check("r0_gnt", d, gntO[d][0], eg[0]);
      check("r1_gnt", d, gntO[d][1], eg[1]);
      check("ram_en", d, ramEn[d], expEn);
      check("ram_we", d, ramWe[d], expWe);
      check("ram_addr", d, ramAddr[d], expAddr);
      check("ram_di", d, ramDi[d], expDi);
      expBusy = 1'b0;
      for (int k = 0; k < 2; k++)
        for (int i = 0; i < sb[d][k].size(); i++)
          if (sb[d][k][i].due >= cyc) expBusy = 1'b1;
      check("busy", d, busyO[d], expBusy);
      for (int k = 0; k < 2; k++) begin
        if (rvO[d][k]) begin
          if (sb[d][k].size() == 0) begin
            check($sformatf("r%0d_rvalid_spurious", k), d, rvO[d][k], 0);
          end else begin
            e = sb[d][k].pop_front();
            check($sformatf("r%0d_do", k), d, doO[d][k], e.data);
            check($sformatf("r%0d_rvalid_cycle", k), d, cyc, e.due);
            lastDo[d][k] = e.data;
          end
        end else begin
          if (sb[d][k].size() > 0 && sb[d][k][0].due <= cyc) begin
            check($sformatf("r%0d_rvalid_missing", k), d, rvO[d][k], 1);
            void'(sb[d][k].pop_front());
          end
          check($sformatf("r%0d_do_hold", k), d, doO[d][k], lastDo[d][k]);
        end
      end
    end
    @(posedge clk);
    #1;
    expEn = 1'b0;
    expWe = 1'b0;
    for (int k = 0; k < 2; k++) begin
      if (eg[k]) begin
        expEn   = 1'b1;
        expWe   = txq[k][0].we;
        expAddr = txq[k][0].addr;
        expDi   = txq[k][0].di;
        if (txq[k][0].we) expMem[txq[k][0].addr] = txq[k][0].di;
        else
          for (int d = 0; d < 2; d++)
            sb[d][k].push_back(sb_t'{expMem[txq[k][0].addr], cyc + latOf(d) + 2});
        ptr = txq[k][0].lock ? (k == 1) : (k == 0);
        void'(txq[k].pop_front());
      end
    end
    cyc++;
  endtask

  task automatic runUntilIdle(int maxc);
    int n = 0;
    while ((txq[0].size() + txq[1].size()) > 0 && n < maxc) begin
      cycle();
      n++;
    end
  endtask

  task automatic applyReset();
    rst_n   = 1'b0;
    ptr     = 1'b0;
    expEn   = 1'b0;
    expWe   = 1'b0;
    expAddr = '0;
    expDi   = '0;
    for (int k = 0; k < 2; k++) begin
      reqI[k] = 1'b0; weI[k] = 1'b0; lockI[k] = 1'b0; addrI[k] = '0; diI[k] = '0;
      txq[k].delete();
      for (int d = 0; d < 2; d++) begin
        sb[d][k].delete();
        lastDo[d][k] = '0;
      end
    end
    #1;
    for (int d = 0; d < 2; d++) begin
      check("rst_ram_en", d, ramEn[d], 0);
      check("rst_ram_we", d, ramWe[d], 0);
      check("rst_ram_addr", d, ramAddr[d], 0);
      check("rst_ram_di", d, ramDi[d], 0);
      check("rst_busy", d, busyO[d], 0);
      for (int k = 0; k < 2; k++) begin
        check($sformatf("rst_r%0d_rvalid", k), d, rvO[d][k], 0);
        check($sformatf("rst_r%0d_do", k), d, doO[d][k], 0);
        check($sformatf("rst_r%0d_gnt", k), d, gntO[d][k], 0);
      end
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic checkSeq(string tag, int expSeq [$]);
    check({tag, "_len"}, 0, hist.size(), expSeq.size());
    for (int i = 0; i < expSeq.size() && i < hist.size(); i++)
      check($sformatf("%s_%0d", tag, i), 0, hist[i], expSeq[i]);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int pat [8] = '{0, 0, 1, 0, 1, 1, 0, 1};
    int seqLock [$];
    int seqAlt [$];
    int n;
    passCnt = 0; failCnt = 0; total = 0; cyc = 0; recording = 1'b0;
    applyReset();

    // Lone requester 0: write then read back
    pushTx(0, 1'b1, 1'b0, 10'h005, 32'hDEADBEEF);
    cycle();
    pushTx(0, 1'b0, 1'b0, 10'h005, '0);
    cycle();

    // Populate 0x10..0x17 from both requesters
    for (int i = 0; i < 8; i++)
      pushTx(i % 2, 1'b1, 1'b0, AW'(10'h010 + i), 32'hA000_0000 + 32'h1111 * i);
    runUntilIdle(40);

    // Back-to-back reads with mixed requesters
    for (int i = 0; i < 8; i++) begin
      pushTx(pat[i], 1'b0, 1'b0, AW'(10'h010 + i), '0);
      cycle();
    end

    // Requester 1 locks a 4-write burst while requester 0 waits
    for (int i = 0; i < 4; i++)
      pushTx(1, 1'b1, 1'b1, AW'(10'h020 + i), 32'hC0DE_0000 + i);
    cycle();
    pushTx(0, 1'b0, 1'b0, 10'h010, '0);
    pushTx(0, 1'b0, 1'b0, 10'h011, '0);
    hist.delete();
    recording = 1'b1;
    runUntilIdle(20);
    recording = 1'b0;
    seqLock = '{1, 1, 1, 0, 0};
    checkSeq("lock_seq", seqLock);

    // Three reads in flight, then reset while a write is on the RAM port
    pushTx(0, 1'b0, 1'b0, 10'h012, '0); cycle();
    pushTx(1, 1'b0, 1'b0, 10'h013, '0); cycle();
    pushTx(0, 1'b0, 1'b0, 10'h014, '0); cycle();
    cycle();
    pushTx(1, 1'b1, 1'b0, 10'h030, 32'h1234_5678); cycle();
    applyReset();

    // Post-reset contention: strict alternation starting with requester 0
    for (int i = 0; i < 4; i++) begin
      pushTx(0, 1'b0, 1'b0, AW'(10'h010 + i), '0);
      pushTx(1, 1'b0, 1'b0, AW'(10'h020 + i), '0);
    end
    hist.delete();
    recording = 1'b1;
    runUntilIdle(20);
    recording = 1'b0;
    seqAlt = '{0, 1, 0, 1, 0, 1, 0, 1};
    checkSeq("alt_seq", seqAlt);

    // Drain outstanding reads, plus a few idle cycles to catch stray pulses
    n = 0;
    while ((sb[0][0].size() + sb[0][1].size() + sb[1][0].size() + sb[1][1].size()) > 0 && n < 40) begin
      cycle();
      n++;
    end
    repeat (4) cycle();

    $display("%0d/%0d checks passed", passCnt, total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/bram_port_arbiter.md
Name: bram_port_arbiter

Overview:
- Shares one port of a true dual-port BRAM (symmetric or asymmetric wrapper instance) between two requesters.
- Typical pairing: requester 0 is the Wishbone bridge, requester 1 is a fabric-side engine.
- Round-robin arbitration with optional burst lock. Accepts one access per cycle.
- Tracks the RAM's fixed read latency and routes each read word back to the requester that issued it.

Parameters:
- WIDTH, 32, data width of the arbitrated RAM port.
- ADDRWIDTH, 10, address width of the arbitrated RAM port.
- RD_LATENCY, 4, cycles from ram_en (read) to valid ram_do; equals N_REGISTERS+1 of the RAM instance; legal range 1..16.

Ports:
- clk  in  1  single clock for arbiter and RAM port.
- rst_n  in  1  reset, asynchronous, active-low.
- r0_req  in  1  requester 0 access request.
- r0_we  in  1  1 = write, 0 = read.
- r0_lock  in  1  hold priority for a burst.
- r0_addr  in  ADDRWIDTH  word address.
- r0_di  in  WIDTH  write data.
- r0_gnt  out  1  request accepted this cycle.
- r0_rvalid  out  1  r0_do holds read data.
- r0_do  out  WIDTH  read data.
- r1_req, r1_we, r1_lock, r1_addr, r1_di, r1_gnt, r1_rvalid, r1_do  same as r0 for requester 1.
- ram_en  out  1  RAM port enable.
- ram_we  out  1  RAM port write enable.
- ram_addr  out  ADDRWIDTH  RAM address.
- ram_di  out  WIDTH  RAM write data.
- ram_do  in  WIDTH  RAM read data.
- busy  out  1  one or more reads in flight.

Behaviour:
- Clock and reset: one clock domain (clk). Reset is asynchronous, active-low (rst_n). Reset values are 0 for every output and for all internal state; priority pointer resets to requester 0.
- Handshake:
  - Requester holds req/we/addr/di/lock stable until it sees gnt.
  - Acceptance = req & gnt in the same cycle.
  - gnt is combinational from req and the priority pointer.
  - At most one gnt per cycle; gnt is never asserted without req.
- Arbitration:
  - Only one requester requesting: it is granted.
  - Both requesting: the pointer's requester is granted.
  - After any acceptance by requester k, the pointer moves to the other requester, unless rk_lock=1 at acceptance, in which case the pointer stays at k.
  - A requester dropping req releases its lock implicitly, because the other requester is then granted.
  - Neither requesting: pointer unchanged.
- RAM drive:
  - ram_en/ram_we/ram_addr/ram_di are registered copies of the accepted request, so the access reaches the RAM 1 cycle after acceptance.
  - ram_en=0 and ram_we=0 on idle cycles; addr/di hold their last value.
- Read return:
  - Each accepted read pushes {valid, tag} into a RD_LATENCY-deep shift register aligned with ram_en.
  - When the head is valid, r{tag}_rvalid=1 for one cycle and r{tag}_do is the registered ram_do.
  - Total read latency = RD_LATENCY+2 cycles from acceptance; rkdo changes only when rkrvalid=1 and holds its value otherwise.
  - Writes produce no rvalid.
- Throughput: one accepted access per cycle sustained, with reads and writes interleaved freely; no internal stalls.
- busy = OR of the valid bits in the shift register plus the return register.
- Ordering: read data per requester returns in issue order.
- Reset mid-operation: in-flight reads are discarded and no rvalid is generated for them; ram_en deasserts immediately (asynchronous).

Test Plan:
- Lone r0: write addr 0x005 data 0xDEADBEEF, then read 0x005 → gnt same cycle as req; ram_en/we high 1 cycle later; r0_rvalid exactly RD_LATENCY+2 cycles after read acceptance with r0_do=0xDEADBEEF; r1_rvalid stays 0.
- Both requesting continuously, no lock, reads of distinct addresses → grants strictly alternate r0,r1,r0,r1 starting with r0 after reset; rvalids alternate with matching data; busy stays high.
- r1 requesting with r1_lock=1 for 4 writes while r0 requests → r1 gets 4 consecutive grants; r0 is granted on the cycle after r1 drops lock or req.
- Back-to-back reads, 8 cycles, mixed requesters (pattern 0,0,1,0,1,1,0,1) → each rvalid pulse goes to the correct requester, in order; no lost or duplicated pulse.
- rst_n asserted 2 cycles after 3 outstanding reads → all outputs 0 immediately; no rvalid after release; first post-reset contention is won by r0.
- RD_LATENCY=1 build, repeat scenario 1 → r0_rvalid 3 cycles after acceptance.
